// File: rtl/spi_tft_byte_tx.sv
// ---------------------------------------------------------------------------
// spi_tft_byte_tx
//   Byte-wide SPI transmitter for a TFT panel controller. Upstream offers one
//   byte at a time (req level + data + D/C); the block shifts it out MSB first
//   (CPOL=0, CPHA=0), pulses ack when the byte has fully left, and keeps CS
//   low across consecutive bytes until upstream raises end.
//
// Ports
//   sys_clk, sys_rst        clock, asynchronous active-high reset
//   spi_send_req_i          byte available (level)
//   spi_send_end_i          close burst and release CS (level, beats req)
//   spi_send_data_i [7:0]   byte to send
//   spi_send_dc_i           D/C for that byte (0 = command, 1 = data)
//   spi_send_ack_o          one-cycle pulse, byte fully shifted out
//   spi_busy_o              high whenever the FSM is not in IDLE
//   tft_sclk_o/mosi_o/cs_o  SPI pins (cs active low)
//   tft_dc_o                D/C pin, holds last latched value
//
// Every output is a flop. Outputs are computed from the *next* state so the
// pins line up with the state they describe without adding a cycle of lag.
// ---------------------------------------------------------------------------
module spi_tft_byte_tx #(
  parameter int CLK_DIV = 2   // SCLK half-period in sys_clk cycles, 1..255
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       spi_send_req_i,
  input  logic       spi_send_end_i,
  input  logic [7:0] spi_send_data_i,
  input  logic       spi_send_dc_i,
  output logic       spi_send_ack_o,
  output logic       spi_busy_o,
  output logic       tft_sclk_o,
  output logic       tft_mosi_o,
  output logic       tft_cs_o,
  output logic       tft_dc_o
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    LOAD    = 3'd1,
    SHIFT   = 3'd2,
    ACK     = 3'd3,
    CHECK   = 3'd4,
    CS_HOLD = 3'd5
  } state_t;

  localparam logic [7:0] HMAX = 8'(CLK_DIV - 1);

  state_t      state, state_d;
  logic [7:0]  hcnt;      // cycles spent in current SCLK half / CS hold
  logic [2:0]  bcnt;      // bit index within the byte, 0 = MSB
  logic [7:0]  sh_q;      // shift register, MSB drives MOSI
  logic        sclk_q;
  logic        dc_q;
  logic        cs_q;
  logic        ack_q;
  logic        busy_q;

  logic half_end, bit_end, byte_end;

  assign half_end = (hcnt == HMAX);
  // A bit ends at the last cycle of its high half.
  assign bit_end  = half_end && sclk_q;
  assign byte_end = bit_end && (bcnt == 3'd7);

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) state <= IDLE;
    else         state <= state_d;
  end

  // -------------------------------------------------------------------------
  // Next-state logic. Inputs are only looked at in IDLE and CHECK (the LOAD
  // entry edge), so anything upstream does during SHIFT/ACK/CS_HOLD is moot.
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state;
    unique case (state)
      IDLE:    if (spi_send_req_i && !spi_send_end_i) state_d = LOAD;
      LOAD:    state_d = SHIFT;
      SHIFT:   if (byte_end) state_d = ACK;
      ACK:     state_d = CHECK;
      CHECK: begin
        if (spi_send_end_i)      state_d = CS_HOLD;
        else if (spi_send_req_i) state_d = LOAD;
      end
      CS_HOLD: if (half_end) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Datapath: byte latch, SCLK generation, bit/half counters.
  // The byte is captured on the edge into LOAD so MOSI already shows bit 7
  // during LOAD.
  // -------------------------------------------------------------------------
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      sh_q   <= 8'h00;
      dc_q   <= 1'b0;
      sclk_q <= 1'b0;
      hcnt   <= 8'h00;
      bcnt   <= 3'd0;
    end else if (state_d == LOAD) begin
      sh_q   <= spi_send_data_i;
      dc_q   <= spi_send_dc_i;
      sclk_q <= 1'b0;
      hcnt   <= 8'h00;
      bcnt   <= 3'd0;
    end else begin
      unique case (state)
        SHIFT: begin
          if (half_end) begin
            hcnt <= 8'h00;
            if (!sclk_q) begin
              sclk_q <= 1'b1;
            end else begin
              // Bit boundary: drop SCLK and present the next bit.
              sclk_q <= 1'b0;
              bcnt   <= bcnt + 3'd1;
              sh_q   <= {sh_q[6:0], 1'b0};
            end
          end else begin
            hcnt <= hcnt + 8'd1;
          end
        end
        CS_HOLD: begin
          sclk_q <= 1'b0;
          hcnt   <= half_end ? 8'h00 : hcnt + 8'd1;
        end
        default: begin
          sclk_q <= 1'b0;
          hcnt   <= 8'h00;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Registered control outputs, decoded from the next state.
  // -------------------------------------------------------------------------
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      cs_q   <= 1'b1;
      ack_q  <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      cs_q   <= (state_d == IDLE) || (state_d == CS_HOLD);
      ack_q  <= (state_d == ACK);
      busy_q <= (state_d != IDLE);
    end
  end

  assign spi_send_ack_o = ack_q;
  assign spi_busy_o     = busy_q;
  assign tft_sclk_o     = sclk_q;
  assign tft_mosi_o     = sh_q[7];
  assign tft_cs_o       = cs_q;
  assign tft_dc_o       = dc_q;

endmodule

// File: tb/tb_spi_tft_byte_tx.sv
// ---------------------------------------------------------------------------
// tb_spi_tft_byte_tx
//   Directed bench for spi_tft_byte_tx. Two instances: CLK_DIV=2 (main) and
//   CLK_DIV=1 (edge case). Expected {dc,byte} pairs are queued when a byte is
//   offered; negedge monitors rebuild each byte from MOSI on SCLK rises and
//   compare against the queue head on every ack.
// ---------------------------------------------------------------------------
module tb_spi_tft_byte_tx;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;

  logic       req0 = 0, end0 = 0, dc0 = 0;
  logic [7:0] data0 = 0;
  logic       ack0, busy0, sclk0, mosi0, cs0, dco0;

  logic       req1 = 0, end1 = 0, dc1 = 0;
  logic [7:0] data1 = 0;
  logic       ack1, busy1, sclk1, mosi1, cs1, dco1;

  int n_tests = 0;
  int n_fail  = 0;

  logic [8:0] exp0_q[$];
  logic [8:0] exp1_q[$];
  int         acks0 = 0, acks1 = 0;
  int         cs_hi = 0;
  bit         burst_mon = 0;
  int         cyc_cnt = 0;

  always #5 sys_clk = ~sys_clk;
  always @(posedge sys_clk) cyc_cnt <= cyc_cnt + 1;

  spi_tft_byte_tx #(.CLK_DIV(2)) u_dut0 (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .spi_send_req_i(req0), .spi_send_end_i(end0),
    .spi_send_data_i(data0), .spi_send_dc_i(dc0),
    .spi_send_ack_o(ack0), .spi_busy_o(busy0),
    .tft_sclk_o(sclk0), .tft_mosi_o(mosi0),
    .tft_cs_o(cs0), .tft_dc_o(dco0)
  );

  spi_tft_byte_tx #(.CLK_DIV(1)) u_dut1 (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .spi_send_req_i(req1), .spi_send_end_i(end1),
    .spi_send_data_i(data1), .spi_send_dc_i(dc1),
    .spi_send_ack_o(ack1), .spi_busy_o(busy1),
    .tft_sclk_o(sclk1), .tft_mosi_o(mosi1),
    .tft_cs_o(cs1), .tft_dc_o(dco1)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---- monitors ----------------------------------------------------------
  logic [7:0] sh0 = 0, sh1 = 0;
  int         nb0 = 0, nb1 = 0;
  logic       sp0 = 0, sp1 = 0;
  int         lr1 = 0;

  always @(negedge sys_clk) begin
    logic [8:0] e;
    if (sys_rst) begin
      nb0 = 0; sh0 = 0;
    end else begin
      if (sclk0 && !sp0) begin sh0 = {sh0[6:0], mosi0}; nb0++; end
      if (burst_mon && cs0) cs_hi++;
      if (ack0) begin
        acks0++;
        if (exp0_q.size() == 0) check("ack0_unexpected", 1, 0);
        else begin
          e = exp0_q.pop_front();
          check("byte0", {23'd0, dco0, sh0}, {23'd0, e});
          check("nbits0", nb0, 8);
        end
        nb0 = 0;
      end
    end
    sp0 = sclk0;
  end

  always @(negedge sys_clk) begin
    logic [8:0] e;
    if (sys_rst) begin
      nb1 = 0; sh1 = 0;
    end else begin
      if (sclk1 && !sp1) begin
        if (nb1 > 0) check("sclk1_period", cyc_cnt - lr1, 2);
        lr1 = cyc_cnt;
        sh1 = {sh1[6:0], mosi1}; nb1++;
      end
      if (ack1) begin
        acks1++;
        if (exp1_q.size() == 0) check("ack1_unexpected", 1, 0);
        else begin
          e = exp1_q.pop_front();
          check("byte1", {23'd0, dco1, sh1}, {23'd0, e});
          check("nbits1", nb1, 8);
        end
        nb1 = 0;
      end
    end
    sp1 = sclk1;
  end

  // ---- helpers -----------------------------------------------------------
  task automatic tick();
    @(posedge sys_clk); #1;
  endtask

  task automatic cyc();
    @(posedge sys_clk); @(negedge sys_clk);
  endtask

  // Counts posedges until ack is seen; returns at the negedge of the ack cycle.
  task automatic wait_ack(input bit sel, output int n);
    n = 0;
    repeat (200) begin
      @(posedge sys_clk); n++;
      @(negedge sys_clk);
      if ((sel ? ack1 : ack0) === 1'b1) return;
    end
    check("ack_timeout", 0, 1);
    n = -1;
  endtask

  // Called at the ack negedge: raise end for CHECK and let CS_HOLD drain.
  task automatic close_burst(input bit sel);
    if (sel) begin req1 = 0; end1 = 1; end else begin req0 = 0; end0 = 1; end
    tick(); tick();
    if (sel) end1 = 0; else end0 = 0;
    repeat (4) tick();
  endtask

  localparam int NB = 11;
  logic [7:0] bdat [NB] = '{8'h2A, 8'h00, 8'h00, 8'h01, 8'h3F, 8'h2B,
                            8'h00, 8'h00, 8'h00, 8'hEF, 8'h2C};
  logic       bdc  [NB] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0,
                            1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  // ---- stimulus ----------------------------------------------------------
  initial begin
    int n, a0, rises;
    logic sp;

    // Reset state
    repeat (3) @(negedge sys_clk);
    check("rst_cs",   cs0,   1);
    check("rst_sclk", sclk0, 0);
    check("rst_mosi", mosi0, 0);
    check("rst_dc",   dco0,  0);
    check("rst_ack",  ack0,  0);
    check("rst_busy", busy0, 0);
    tick(); sys_rst = 0;
    repeat (3) tick();
    check("idle_busy", busy0, 0);

    // Single byte 0x2A command
    data0 = 8'h2A; dc0 = 0; req0 = 1; exp0_q.push_back({1'b0, 8'h2A});
    wait_ack(0, n);
    check("single_ack_lat", n, 34);
    check("single_cs_ack", cs0, 0);
    req0 = 0; end0 = 1;
    cyc(); check("single_cs_check", cs0, 0);
    cyc(); check("single_cs_hold1", cs0, 1); end0 = 0;
    cyc(); check("single_cs_hold2", cs0, 1); check("single_busy_hold", busy0, 1);
    cyc(); check("single_idle_busy", busy0, 0); check("single_dc_hold", dco0, 0);
    repeat (2) tick();

    // 11-byte burst, req held high, new data in CHECK
    data0 = bdat[0]; dc0 = bdc[0]; req0 = 1; exp0_q.push_back({bdc[0], bdat[0]});
    wait_ack(0, n);
    check("burst_first_lat", n, 34);
    burst_mon = 1;
    for (int i = 1; i < NB; i++) begin
      tick();
      data0 = bdat[i]; dc0 = bdc[i]; exp0_q.push_back({bdc[i], bdat[i]});
      wait_ack(0, n);
      check("burst_period", n + 1, 35);
    end
    burst_mon = 0;
    check("burst_cs_low", cs_hi, 0);
    check("burst_dc_last", dco0, 0);
    close_burst(0);
    check("burst_acks", acks0, 12);

    // End beats req in CHECK
    data0 = 8'h55; dc0 = 1; req0 = 1; exp0_q.push_back({1'b1, 8'h55});
    wait_ack(0, n);
    check("prio_lat", n, 34);
    tick(); end0 = 1;
    @(negedge sys_clk); check("prio_cs_check", cs0, 0);
    cyc(); check("prio_cs_hold1", cs0, 1);
    cyc(); check("prio_cs_hold2", cs0, 1); check("prio_busy", busy0, 1);
    cyc(); check("prio_idle", busy0, 0);
    a0 = acks0;
    repeat (5) cyc();
    check("prio_no_load", busy0, 0);
    check("prio_no_ack", acks0, a0);
    check("prio_dc_hold", dco0, 1);
    req0 = 0; end0 = 0;
    tick();

    // Reset during the 4th SCLK high phase
    data0 = 8'hA5; dc0 = 1; req0 = 1; exp0_q.push_back({1'b1, 8'hA5});
    rises = 0; sp = 0; a0 = acks0;
    for (int k = 0; k < 200 && rises < 4; k++) begin
      @(negedge sys_clk);
      if (sclk0 && !sp) rises++;
      sp = sclk0;
    end
    check("rst_mid_reached", rises, 4);
    sys_rst = 1; req0 = 0;
    #1;
    check("rst_mid_cs", cs0, 1);
    check("rst_mid_sclk", sclk0, 0);
    check("rst_mid_ack", ack0, 0);
    check("rst_mid_busy", busy0, 0);
    void'(exp0_q.pop_back());
    repeat (2) tick();
    sys_rst = 0;
    repeat (3) cyc();
    check("rst_mid_no_ack", acks0, a0);
    check("rst_mid_idle", busy0, 0);
    tick();
    data0 = 8'h3C; dc0 = 0; req0 = 1; exp0_q.push_back({1'b0, 8'h3C});
    wait_ack(0, n);
    check("rst_after_lat", n, 34);
    close_burst(0);

    // Inputs toggled during SHIFT must not leak into the byte
    data0 = 8'h96; dc0 = 1; req0 = 1; exp0_q.push_back({1'b1, 8'h96});
    tick(); tick();               // LOAD, then first SHIFT cycle
    n = 2;
    for (int k = 0; k < 200 && ack0 !== 1'b1; k++) begin
      data0 = ~data0; dc0 = ~dc0;
      @(posedge sys_clk); n++;
      @(negedge sys_clk);
    end
    check("stable_lat", n, 34);
    dc0 = 1;
    close_burst(0);

    // CLK_DIV = 1
    data1 = 8'hFF; dc1 = 1; req1 = 1; exp1_q.push_back({1'b1, 8'hFF});
    wait_ack(1, n);
    check("div1_lat", n, 18);
    tick();
    data1 = 8'h81; dc1 = 0; exp1_q.push_back({1'b0, 8'h81});
    wait_ack(1, n);
    check("div1_period", n + 1, 19);
    close_burst(1);
    check("div1_acks", acks1, 2);
    check("div1_idle", busy1, 0);

    check("q0_drained", exp0_q.size(), 0);
    check("q1_drained", exp1_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
